// File: rtl/vga_tabuleiro_pkg.sv
// Shared definitions for the battleship board display: cell codes, colours,
// loader FSM states and default board geometry.
package vga_tabuleiro_pkg;

    // Cell codes stored in the board RAM
    localparam logic [2:0] AGUA        = 3'd0;
    localparam logic [2:0] SUBMARINO   = 3'd1;
    localparam logic [2:0] CRUZADOR    = 3'd2;
    localparam logic [2:0] HIDROAVIAO  = 3'd3;
    localparam logic [2:0] ENCOURACADO = 3'd4;
    localparam logic [2:0] PORTAAVIOES = 3'd5;
    localparam logic [2:0] ACERTO      = 3'd6;
    localparam logic [2:0] ERRO        = 3'd7;

    // Colours as {r, g, b}
    localparam logic [2:0] COR_PRETO    = 3'b000;
    localparam logic [2:0] COR_AZUL     = 3'b001;
    localparam logic [2:0] COR_VERDE    = 3'b010;
    localparam logic [2:0] COR_CIANO    = 3'b011;
    localparam logic [2:0] COR_VERMELHO = 3'b100;
    localparam logic [2:0] COR_MAGENTA  = 3'b101;
    localparam logic [2:0] COR_AMARELO  = 3'b110;
    localparam logic [2:0] COR_BRANCO   = 3'b111;

    // Snapshot loader states
    typedef enum logic [1:0] {
        ESPERA = 2'd0,
        CARGA  = 2'd1,
        FIM    = 2'd2
    } estado_t;

    // Default board geometry
    localparam int unsigned X0_PAD        = 16;
    localparam int unsigned Y0_PAD        = 16;
    localparam int unsigned PASSO_X_PAD   = 62;
    localparam int unsigned PASSO_Y_PAD   = 57;
    localparam int unsigned LARGURA_PAD   = 54;
    localparam int unsigned ALTURA_PAD    = 49;
    localparam int unsigned V_ATIVO_PAD   = 480;
    localparam int unsigned BLINK_BIT_PAD = 4;

    function automatic logic [2:0] cor_celula(input logic [2:0] codigo);
        logic [2:0] cor;
        case (codigo)
            AGUA:        cor = COR_AZUL;
            SUBMARINO:   cor = COR_VERDE;
            CRUZADOR:    cor = COR_VERMELHO;
            HIDROAVIAO:  cor = COR_AMARELO;
            ENCOURACADO: cor = COR_MAGENTA;
            PORTAAVIOES: cor = COR_CIANO;
            ACERTO:      cor = COR_BRANCO;
            ERRO:        cor = COR_PRETO;
            default:     cor = COR_PRETO;
        endcase
        return cor;
    endfunction

endpackage

// File: rtl/vga_celula_decod.sv
// Single-axis cell decoder: finds which of the 8 cells a pixel coordinate
// falls into (both cell borders exclusive) and flags the 2-pixel outline band.
module vga_celula_decod #(
    parameter int unsigned OFFSET  = 16,
    parameter int unsigned PASSO   = 62,
    parameter int unsigned TAMANHO = 54
) (
    input  logic [9:0] i_pos,
    output logic       o_valido,
    output logic [2:0] o_indice,
    output logic       o_borda
);

    logic [31:0] w_pos;
    assign w_pos = {22'd0, i_pos};

    // Comparator chain over the 8 cells; cells never overlap
    always_comb begin
        logic [31:0] w_lo;
        o_valido = 1'b0;
        o_indice = 3'd0;
        o_borda  = 1'b0;
        w_lo     = 32'd0;
        for (int k = 0; k < 8; k++) begin
            w_lo = OFFSET + PASSO * 32'(k);
            if ((w_pos > w_lo) && (w_pos < w_lo + TAMANHO)) begin
                o_valido = 1'b1;
                o_indice = 3'(k);
                o_borda  = (w_pos <= w_lo + 32'd2) || (w_pos >= w_lo + TAMANHO - 32'd2);
            end
        end
    end

endmodule

// File: rtl/vga_tabuleiro_ctrl.sv
// Board display controller: snapshots the 8x8 board RAM into a shadow file
// during vertical blanking and renders cells plus a blinking cursor outline.
module vga_tabuleiro_ctrl
    import vga_tabuleiro_pkg::*;
#(
    parameter int unsigned X0        = X0_PAD,
    parameter int unsigned Y0        = Y0_PAD,
    parameter int unsigned PASSO_X   = PASSO_X_PAD,
    parameter int unsigned PASSO_Y   = PASSO_Y_PAD,
    parameter int unsigned LARGURA   = LARGURA_PAD,
    parameter int unsigned ALTURA    = ALTURA_PAD,
    parameter int unsigned V_ATIVO   = V_ATIVO_PAD,
    parameter int unsigned BLINK_BIT = BLINK_BIT_PAD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       areaAtiva,
    input  logic [9:0] linha,
    input  logic [9:0] coluna,
    output logic [5:0] mem_addr,
    output logic       mem_rd,
    input  logic [2:0] mem_dado,
    input  logic       carga_req,
    output logic       carga_ack,
    output logic       ocupado,
    input  logic       cursor_en,
    input  logic [2:0] cursor_x,
    input  logic [2:0] cursor_y,
    output logic       rgb_r,
    output logic       rgb_g,
    output logic       rgb_b
);

    // ---------------- Frame timing ----------------
    logic       w_vblank;
    logic       w_vblank_ini;
    logic       r_vblank;
    logic [4:0] r_cnt;

    assign w_vblank     = (linha >= 10'(V_ATIVO));
    assign w_vblank_ini = w_vblank & ~r_vblank;

    // Vblank edge detector and blink frame counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vblank <= 1'b0;
            r_cnt    <= 5'd0;
        end else begin
            r_vblank <= w_vblank;
            if (w_vblank_ini) begin
                r_cnt <= r_cnt + 5'd1;
            end
        end
    end

    // ---------------- Snapshot loader ----------------
    estado_t    r_estado;
    estado_t    w_estado_prox;
    logic [5:0] r_addr;
    logic [5:0] w_addr_prox;
    logic       r_ack;
    logic       w_ack_prox;
    logic       r_rd_ant;
    logic [5:0] r_addr_ant;
    logic [2:0] r_sombra [64];

    // Loader state, address counter and registered ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado <= ESPERA;
            r_addr   <= 6'd0;
            r_ack    <= 1'b0;
        end else begin
            r_estado <= w_estado_prox;
            r_addr   <= w_addr_prox;
            r_ack    <= w_ack_prox;
        end
    end

    // Loader next state: sweep 64 addresses, then one FIM cycle for the last datum
    always_comb begin
        w_estado_prox = r_estado;
        w_addr_prox   = r_addr;
        w_ack_prox    = 1'b0;
        unique case (r_estado)
            ESPERA: begin
                if (carga_req && w_vblank) begin
                    w_estado_prox = CARGA;
                    w_addr_prox   = 6'd0;
                end
            end
            CARGA: begin
                w_addr_prox = r_addr + 6'd1;
                if (r_addr == 6'd63) begin
                    w_estado_prox = FIM;
                end
            end
            FIM: begin
                w_ack_prox    = 1'b1;
                w_estado_prox = ESPERA;
            end
            default: w_estado_prox = ESPERA;
        endcase
    end

    assign mem_rd    = (r_estado == CARGA);
    assign ocupado   = (r_estado != ESPERA);
    assign mem_addr  = r_addr;
    assign carga_ack = r_ack;

    // RAM data arrives one clock after the read, so write with the delayed address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ant   <= 1'b0;
            r_addr_ant <= 6'd0;
            for (int i = 0; i < 64; i++) begin
                r_sombra[i] <= AGUA;
            end
        end else begin
            r_rd_ant   <= mem_rd;
            r_addr_ant <= r_addr;
            if (r_rd_ant) begin
                r_sombra[r_addr_ant] <= mem_dado;
            end
        end
    end

    // ---------------- Pixel pipeline ----------------
    logic       w_valido_x;
    logic       w_valido_y;
    logic [2:0] w_idx_x;
    logic [2:0] w_idx_y;
    logic       w_borda_x;
    logic       w_borda_y;

    vga_celula_decod #(
        .OFFSET  (X0),
        .PASSO   (PASSO_X),
        .TAMANHO (LARGURA)
    ) u_decod_x (
        .i_pos    (coluna),
        .o_valido (w_valido_x),
        .o_indice (w_idx_x),
        .o_borda  (w_borda_x)
    );

    vga_celula_decod #(
        .OFFSET  (Y0),
        .PASSO   (PASSO_Y),
        .TAMANHO (ALTURA)
    ) u_decod_y (
        .i_pos    (linha),
        .o_valido (w_valido_y),
        .o_indice (w_idx_y),
        .o_borda  (w_borda_y)
    );

    logic       r_dentro;
    logic [2:0] r_cx;
    logic [2:0] r_cy;
    logic       r_borda;
    logic       r_area;
    logic [2:0] r_rgb;
    logic [2:0] w_rgb;

    // Stage 1: register the decoded cell; row slot 0 is the top row, cy = 7
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dentro <= 1'b0;
            r_cx     <= 3'd0;
            r_cy     <= 3'd0;
            r_borda  <= 1'b0;
            r_area   <= 1'b0;
        end else begin
            r_dentro <= w_valido_x & w_valido_y;
            r_cx     <= w_idx_x;
            r_cy     <= ~w_idx_y;
            r_borda  <= w_borda_x | w_borda_y;
            r_area   <= areaAtiva;
        end
    end

    // Stage 2 colour select: blank, then cursor outline, then cell colour
    always_comb begin
        w_rgb = COR_PRETO;
        if (r_area && r_dentro) begin
            if (cursor_en && (r_cx == cursor_x) && (r_cy == cursor_y) && r_borda &&
                r_cnt[BLINK_BIT]) begin
                w_rgb = COR_BRANCO;
            end else begin
                w_rgb = cor_celula(r_sombra[{r_cy, r_cx}]);
            end
        end
    end

    // Stage 2 register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb <= COR_PRETO;
        end else begin
            r_rgb <= w_rgb;
        end
    end

    assign rgb_r = r_rgb[2];
    assign rgb_g = r_rgb[1];
    assign rgb_b = r_rgb[0];

endmodule

// File: doc/vga_tabuleiro_ctrl.md
Name: vga_tabuleiro_ctrl

Overview:
- Frame-level controller for the 8x8 battleship board display.
- During vertical blanking it reads an 8x8 board-state RAM (one 3-bit ship/marker code per cell) into a 64-entry shadow register file, on request from game logic.
- During active video it maps each pixel (linha, coluna) to a grid cell and drives the 1-bit rgb channels from the shadowed cell code, plus a blinking cursor outline.
- Replaces per-ship single-cell drawers with one shared, sequenced renderer.

Parameters:
- X0, 16: left pixel offset of column 0. Cell border is exclusive.
- Y0, 16: top pixel offset of the top board row (cy=7). Cell border is exclusive.
- PASSO_X, 62: horizontal cell pitch in pixels.
- PASSO_Y, 57: vertical cell pitch in pixels.
- LARGURA, 54: cell width in pixels (exclusive bounds).
- ALTURA, 49: cell height in pixels (exclusive bounds).
- V_ATIVO, 480: first line number counted as vertical blank.
- BLINK_BIT, 4: frame-counter bit used for the cursor blink phase.

Ports:
- clk  in  1  system/pixel clock
- rst_n  in  1  asynchronous, active-low reset
- areaAtiva  in  1  active video area
- linha  in  10  current line
- coluna  in  10  current column
- mem_addr  out  6  board RAM address, {cy[2:0], cx[2:0]}
- mem_rd  out  1  board RAM read strobe
- mem_dado  in  3  RAM data, valid exactly 1 clk after mem_rd
- carga_req  in  1  level: game requests a new snapshot
- carga_ack  out  1  one-clk pulse: snapshot complete
- ocupado  out  1  high while loading
- cursor_en  in  1  enable cursor outline
- cursor_x  in  3  cursor cell column
- cursor_y  in  3  cursor cell row
- rgb_r  out  1  red channel
- rgb_g  out  1  green channel
- rgb_b  out  1  blue channel

Behaviour:
- Reset (async, rst_n=0):
  - state=ESPERA.
  - mem_addr=0, mem_rd=0, carga_ack=0, ocupado=0, rgb=000.
  - All 64 shadow entries=0; frame counter=0; pipeline flags cleared.
  - Reset mid-load aborts the load with no ack.
- vblank = (linha >= V_ATIVO). vblank_ini = rising edge of vblank (registered compare); the 5-bit frame counter increments on it and wraps 31->0.
- FSM:
  - ESPERA: if carga_req && vblank, go to CARGA with addr=0.
  - CARGA: mem_rd=1, ocupado=1, and mem_addr increments every clk from 0 to 63. Data from the previous cycle's read is written to shadow[addr_d]. After addr 63 is issued, go to FIM.
  - FIM: mem_rd=0. Capture entry 63, pulse carga_ack for 1 clk, go to ESPERA.
- Load timing: 66 clks from CARGA entry to ack.
- Load continues to completion even if vblank ends or carga_req drops. Tearing in that case is acceptable.
- If carga_req is still high in ESPERA during the same or a later vblank, a new load starts (one ack per load).
- Cell decode, per axis:
  - cx = k if coluna is in (X0+PASSO_X*k, X0+PASSO_X*k+LARGURA).
  - Row slot j=0..7 is linha in (Y0+PASSO_Y*j, Y0+PASSO_Y*j+ALTURA), with cy = 7-j.
  - Pixels outside every cell are "fora".
  - borda = the pixel is within the first or last 2 interior pixels of its cell on either axis.
- Pixel pipeline, latency 2 clks from linha/coluna/areaAtiva to rgb. The sync generator delays hsync/vsync by 2 to match.
  - S1 registers: dentro, cx, cy, borda, areaAtiva.
  - S2 registers rgb.
- Colours {r,g,b} by cell code:
  - 0 agua -> 001
  - 1 submarino -> 010
  - 2 cruzador -> 100
  - 3 hidroaviao -> 110
  - 4 encouracado -> 101
  - 5 porta-avioes -> 011
  - 6 acerto -> 111
  - 7 erro -> 000
- Priority: !areaAtiva or fora -> 000. Otherwise, if cursor_en && (cx,cy)==(cursor_x,cursor_y) && borda && cnt[BLINK_BIT] -> 111. Otherwise the colour of the shadow code.
- Shadow writes and pixel reads of the same entry in one clk: the pixel path sees the old value.

Decomposition:
- Package vga_tabuleiro_pkg: cell code constants (AGUA..ERRO), colour constants, FSM state encoding, and geometry defaults.
- One sub-module, vga_celula_decod: a single-axis comparator chain (parameters offset, pitch, size) giving valido, indice[2:0] and borda. It is instantiated twice: the column instance uses X0/PASSO_X/LARGURA, and the row instance uses Y0/PASSO_Y/ALTURA with its index inverted.

Test Plan:
- Reset mid-CARGA at addr 20 -> ocupado=0, no ack, all shadow=0. Pixel (linha 40, coluna 40) -> rgb 001 two clks later.
- RAM cell 0 (cx0,cy0)=1, cell 63=5. Assert carga_req with linha=500 -> mem_rd high for addr 0..63, ack at clk 66. Pixel (440,40) -> 010; pixel (40,40+62*7) -> 011.
- Boundary: coluna=16 or 70 with linha=40 -> 000; coluna=17 and 69 -> the cell colour; linha=65 -> 000.
- carga_req high while linha<480 -> no mem_rd until linha reaches 480. Req held over two vblanks -> two acks.
- cursor_en=1, cursor=(0,7): cnt[4]=1 -> (17,17) gives 111 and (40,40) gives the cell colour. After 16 vblank_ini edges, (17,17) -> the cell colour.
- areaAtiva=0 inside a cell -> 000. A load during active video via vblank start writes only during vblank, with no rgb glitch.
